rom_select_latch: RTL

- Upstream stage of the Teensy35 ROM board's output path. It decodes the CPC upper-ROM select I/O write (port &DFxx, A13=0) and latches the selected ROM number.
- It produces the registered romvalid qualifier that drives the NAND glue. It also produces the ROMDIS pre-drive (romdis_pre, to diode) and the 74245 output enable (bufoe_b).
- It replaces software ROM-select tracking with a CPLD-resident block clocked by the CPC Z80 clock.

---
 rtl/rom_board_pkg.sv | 36 +++
 rtl/io_write_capture.sv | 93 +++++++++
 rtl/rom_select_latch.sv | 82 ++++++++
 3 files changed

// File: rtl/rom_board_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_board_pkg
// Purpose  : Shared definitions for the Teensy35 ROM board CPLD output path:
//            the ROM-select capture FSM states, the address bit that decodes
//            the CPC upper-ROM select port, and the default slot window.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rom_board_pkg;

  // Capture FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } cap_state_t;

  // Address bit that must be low for a write to reach the ROM-select port
  // (&DFxx on the CPC).
  localparam int ROMSEL_PORT_ABIT = 13;

  // Default window: ROMs 0..15, with ROM 0 (BASIC) left to the CPC.
  localparam logic [7:0]  DEFAULT_SLOT_BASE   = 8'h00;
  localparam logic [15:0] DEFAULT_ENABLE_MASK = 16'hFFFE;

  // True when a ROM number falls inside the board's window and its slot is
  // enabled.
  function automatic logic rom_in_window(input logic [7:0]  num,
                                         input logic [3:0]  base_hi,
                                         input logic [15:0] mask);
    return (num[7:4] == base_hi) & mask[num[3:0]];
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_write_capture.sv
`default_nettype none
// ============================================================================
// Module   : io_write_capture
// Purpose  : Samples the Z80 bus once per clock, decodes I/O writes to the
//            upper-ROM select port and captures the written byte. A one-cycle
//            commit pulse is produced once the write strobe has been released.
// Ports    : clk, rst_n           - Z80 clock, async active-low reset
//            ioreq_b, wr_b, m1_b  - Z80 bus strobes (active low)
//            a13                  - port decode address bit
//            d                    - data bus
//            commit               - high for the single COMMIT cycle
//            cap                  - captured ROM number (valid with commit)
// Revision : 1.0 - initial release
// ============================================================================
module io_write_capture
  import rom_board_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ioreq_b,
  input  logic       wr_b,
  input  logic       m1_b,
  input  logic       a13,
  input  logic [7:0] d,
  output logic       commit,
  output logic [7:0] cap
);

  // Bus samples. These signals are already in the Z80 clock domain, so a
  // single register stage is enough.
  logic       r_ioreq_b_s;
  logic       r_wr_b_s;
  logic       r_m1_b_s;
  logic       r_a13_s;
  logic [7:0] r_d_s;

  logic       w_io_wr;
  cap_state_t r_state;
  cap_state_t w_state_nxt;
  logic [7:0] r_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ioreq_b_s <= 1'b0;
      r_wr_b_s    <= 1'b0;
      r_m1_b_s    <= 1'b0;
      r_a13_s     <= 1'b0;
      r_d_s       <= 8'h00;
    end else begin
      r_ioreq_b_s <= ioreq_b;
      r_wr_b_s    <= wr_b;
      r_m1_b_s    <= m1_b;
      r_a13_s     <= a13;
      r_d_s       <= d;
    end
  end

  // M1 high rejects interrupt-acknowledge cycles; the cleared reset value of
  // the M1 sample therefore also prevents a spurious write out of reset.
  assign w_io_wr = ~r_ioreq_b_s & ~r_wr_b_s & r_m1_b_s & ~r_a13_s;

  // An active write always leads to CAPTURE, regardless of current state, so
  // a strobe that starts during COMMIT is picked up without a gap.
  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = w_io_wr ? CAPTURE : IDLE;
      CAPTURE: w_state_nxt = w_io_wr ? CAPTURE : COMMIT;
      COMMIT:  w_state_nxt = w_io_wr ? CAPTURE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The byte is reloaded on every sampled strobe cycle, so the last value
  // before release is the one committed. Loading during COMMIT is harmless:
  // the consumer samples the old value on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cap   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_io_wr) begin
        r_cap <= r_d_s;
      end
    end
  end

  assign commit = (r_state == COMMIT);
  assign cap    = r_cap;

endmodule
`default_nettype wire

// File: rtl/rom_select_latch.sv
`default_nettype none
// ============================================================================
// Module   : rom_select_latch
// Purpose  : Tracks the CPC upper-ROM selection and drives the read-path
//            qualifiers for the Teensy35 ROM board: latched slot index,
//            romvalid, ROMDIS pre-drive and the 74245 output enable.
// Ports    : CLK, RESET_B            - Z80 clock, async active-low reset
//            IOREQ_B, WR_B, M1_B     - Z80 bus strobes (active low)
//            ROMEN_B                 - CPC ROM enable (active low)
//            A15, A14, A13           - address bits
//            D                       - data bus
//            rom_sel                 - latched slot index
//            romvalid                - selection is in window and enabled
//            romsel_wr               - one-clock pulse per committed write
//            romdis_pre              - ROMDIS drive through diode
//            bufoe_b                 - 74245 output enable (active low)
// Revision : 1.0 - initial release
// ============================================================================
module rom_select_latch
  import rom_board_pkg::*;
#(
  parameter logic [7:0]  SLOT_BASE   = DEFAULT_SLOT_BASE,
  parameter logic [15:0] ENABLE_MASK = DEFAULT_ENABLE_MASK
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       IOREQ_B,
  input  logic       WR_B,
  input  logic       M1_B,
  input  logic       ROMEN_B,
  input  logic       A15,
  input  logic       A14,
  input  logic       A13,
  input  logic [7:0] D,
  output logic [3:0] rom_sel,
  output logic       romvalid,
  output logic       romsel_wr,
  output logic       romdis_pre,
  output logic       bufoe_b
);

  logic       w_commit;
  logic [7:0] w_cap;
  logic [3:0] r_rom_sel;
  logic       r_romvalid;

  io_write_capture u_capture (
    .clk     (CLK),
    .rst_n   (RESET_B),
    .ioreq_b (IOREQ_B),
    .wr_b    (WR_B),
    .m1_b    (M1_B),
    .a13     (A13),
    .d       (D),
    .commit  (w_commit),
    .cap     (w_cap)
  );

  // Slot index loads unconditionally on commit; only romvalid reflects
  // whether the board actually serves that ROM.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_rom_sel  <= 4'h0;
      r_romvalid <= 1'b0;
    end else if (w_commit) begin
      r_rom_sel  <= w_cap[3:0];
      r_romvalid <= rom_in_window(w_cap, SLOT_BASE[7:4], ENABLE_MASK);
    end
  end

  assign rom_sel   = r_rom_sel;
  assign romvalid  = r_romvalid;
  assign romsel_wr = w_commit;

  // Read path is combinational from the raw pins for bus timing; only the
  // registered romvalid gates it. ROMEN_B is part of the OE term so the
  // buffer can never drive the bus outside a ROM read.
  assign romdis_pre = r_romvalid & A15 & A14;
  assign bufoe_b    = ~(~ROMEN_B & A15 & A14 & r_romvalid);

endmodule
`default_nettype wire
